ahbpassthru_ctrl: RTL and testbench

Sequencing controller for the off-chip AHB pass-through path. It sits between the on-chip AHB slave port and the off-chip pins. It registers each accepted transfer and presents it off-chip as a single NONSEQ transfer. It then waits for the off-chip response and returns a registered read data/response on-chip. If the off-chip device stalls too long, it ends the transfer with a two-cycle AHB ERROR and counts the fault.

---
 rtl/ahbpassthru_pkg.sv | 28 ++
 rtl/ahbpassthru_tmo.sv | 27 ++
 rtl/ahbpassthru_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ahbpassthru_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbpassthru_pkg.sv
// Shared definitions for the off-chip AHB pass-through controller:
// bus encodings, controller state encoding and a saturating counter helper.
package ahbpassthru_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [1:0] HRESP_RETRY   = 2'b10;
    localparam logic [1:0] HRESP_SPLIT   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR1 = 3'd4,
        ST_ERR2 = 3'd5
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ahbpassthru_tmo.sv
// Off-chip data-phase watchdog: counts stalled cycles and strobes o_expire
// in the stalled cycle where the count has reached TIMEOUT-1.
module ahbpassthru_tmo #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] r_cnt;

    assign o_expire = i_en && (r_cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (!rstn || i_clr) begin
            r_cnt <= 16'd0;
        end else if (i_en && !o_expire) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/ahbpassthru_ctrl.sv
// Sequencer between the on-chip AHB slave port and the off-chip pins: each
// accepted transfer is replayed off-chip as one registered NONSEQ transfer.
module ahbpassthru_ctrl
    import ahbpassthru_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 hsel,
    input  logic [31:0]          haddr,
    input  logic                 hwrite,
    input  logic [1:0]           htrans,
    input  logic [2:0]           hsize,
    input  logic [DATAWIDTH-1:0] hwdata,
    input  logic                 hready,
    output logic                 hready_o,
    output logic [1:0]           hresp,
    output logic [DATAWIDTH-1:0] hrdata,
    output logic                 pt_hsel,
    output logic [31:0]          pt_haddr,
    output logic                 pt_hwrite,
    output logic [1:0]           pt_htrans,
    output logic [2:0]           pt_hsize,
    output logic [DATAWIDTH-1:0] pt_hwdata,
    input  logic                 pt_hready,
    input  logic [1:0]           pt_hresp,
    input  logic [DATAWIDTH-1:0] pt_hrdata,
    output logic                 timeout_o,
    output logic [15:0]          err_cnt,
    output logic [2:0]           o_dbg_state
);

    state_t                r_state;
    state_t                w_next;
    logic [31:0]           r_addr;
    logic                  r_write;
    logic [2:0]            r_size;
    logic [DATAWIDTH-1:0]  r_wdata;
    logic [DATAWIDTH-1:0]  r_rdata;
    logic                  r_timeout;
    logic [15:0]           r_err_cnt;

    logic                  w_accept;
    logic                  w_load;
    logic                  w_expire;
    logic                  w_tmo_clr;
    logic                  w_tmo_en;
    logic                  w_rd_capture;
    logic                  w_err_entry;
    logic                  w_hready_o;
    logic [1:0]            w_hresp;
    logic                  w_pt_hsel;
    logic [1:0]            w_pt_htrans;

    // Only NONSEQ/SEQ on a ready, selected bus start an off-chip transfer.
    assign w_accept = hsel && hready &&
                      ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    assign w_load   = w_accept && ((r_state == ST_IDLE) || (r_state == ST_RESP));

    assign w_tmo_clr = (r_state == ST_ADDR);
    assign w_tmo_en  = (r_state == ST_DATA) && !pt_hready;

    ahbpassthru_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk      (clk),
        .rstn     (rstn),
        .i_clr    (w_tmo_clr),
        .i_en     (w_tmo_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_ADDR;
                end
            end
            ST_ADDR: w_next = ST_DATA;
            ST_DATA: begin
                // A ready in the threshold cycle is a completion, never a timeout.
                if (pt_hready) begin
                    w_next = (pt_hresp == HRESP_OKAY) ? ST_RESP : ST_ERR1;
                end else if (w_expire) begin
                    w_next = ST_ERR1;
                end
            end
            ST_RESP: w_next = w_accept ? ST_ADDR : ST_IDLE;
            ST_ERR1: w_next = ST_ERR2;
            // Address phase overlapping the second ERROR cycle is cancelled.
            ST_ERR2: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_hready_o  = 1'b1;
        w_hresp     = HRESP_OKAY;
        w_pt_hsel   = 1'b0;
        w_pt_htrans = HTRANS_IDLE;
        case (r_state)
            ST_ADDR: begin
                w_hready_o  = 1'b0;
                w_pt_hsel   = 1'b1;
                w_pt_htrans = HTRANS_NONSEQ;
            end
            ST_DATA: w_hready_o = 1'b0;
            ST_ERR1: begin
                w_hready_o = 1'b0;
                w_hresp    = HRESP_ERROR;
            end
            ST_ERR2: w_hresp = HRESP_ERROR;
            default: begin
                w_hready_o = 1'b1;
                w_hresp    = HRESP_OKAY;
            end
        endcase
    end

    assign w_rd_capture = (r_state == ST_DATA) && pt_hready &&
                          (pt_hresp == HRESP_OKAY) && !r_write;
    assign w_err_entry  = (r_state == ST_DATA) && (w_next == ST_ERR1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_addr    <= 32'd0;
            r_write   <= 1'b0;
            r_size    <= 3'd0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
            r_err_cnt <= 16'd0;
        end else begin
            if (w_load) begin
                r_addr  <= haddr;
                r_write <= hwrite;
                r_size  <= hsize;
            end
            if (r_state == ST_ADDR) begin
                r_wdata <= hwdata;
            end
            if (w_rd_capture) begin
                r_rdata <= pt_hrdata;
            end
            r_timeout <= (r_state == ST_DATA) && w_expire;
            if (w_err_entry) begin
                r_err_cnt <= sat_inc16(r_err_cnt);
            end
        end
    end

    assign hready_o    = w_hready_o;
    assign hresp       = w_hresp;
    assign hrdata      = r_rdata;
    assign pt_hsel     = w_pt_hsel;
    assign pt_haddr    = r_addr;
    assign pt_hwrite   = r_write;
    assign pt_htrans   = w_pt_htrans;
    assign pt_hsize    = r_size;
    assign pt_hwdata   = r_wdata;
    assign timeout_o   = r_timeout;
    assign err_cnt     = r_err_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ahbpassthru_ctrl.sv
// Bench for ahbpassthru_ctrl: a small off-chip slave model, a transfer driver
// and one task per scenario with an expected-read-data queue.
module tb_ahbpassthru_ctrl;
    import ahbpassthru_pkg::*;

    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          hsel;
    logic [31:0]   haddr;
    logic          hwrite;
    logic [1:0]    htrans;
    logic [2:0]    hsize;
    logic [DW-1:0] hwdata;
    logic          hready;
    logic          hready_o;
    logic [1:0]    hresp;
    logic [DW-1:0] hrdata;
    logic          pt_hsel;
    logic [31:0]   pt_haddr;
    logic          pt_hwrite;
    logic [1:0]    pt_htrans;
    logic [2:0]    pt_hsize;
    logic [DW-1:0] pt_hwdata;
    logic          pt_hready;
    logic [1:0]    pt_hresp;
    logic [DW-1:0] pt_hrdata;
    logic          timeout_o;
    logic [15:0]   err_cnt;
    logic [2:0]    o_dbg_state;

    int total = 0;
    int bad   = 0;
    int exp_err = 0;
    logic [DW-1:0] exp_q[$];

    ahbpassthru_ctrl #(.DATAWIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
        .htrans(htrans), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hready_o(hready_o), .hresp(hresp), .hrdata(hrdata),
        .pt_hsel(pt_hsel), .pt_haddr(pt_haddr), .pt_hwrite(pt_hwrite),
        .pt_htrans(pt_htrans), .pt_hsize(pt_hsize), .pt_hwdata(pt_hwdata),
        .pt_hready(pt_hready), .pt_hresp(pt_hresp), .pt_hrdata(pt_hrdata),
        .timeout_o(timeout_o), .err_cnt(err_cnt), .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    // off-chip slave: inserts cfg_waits wait states, then answers cfg_resp
    int            cfg_waits = 0;
    logic [1:0]    cfg_resp  = HRESP_OKAY;
    logic [DW-1:0] cfg_rdata = '0;
    logic          s_busy    = 1'b0;
    int            s_left    = 0;

    always @(posedge clk) begin
        if (!rstn) begin
            s_busy <= 1'b0;
        end else if (pt_hsel && pt_htrans == HTRANS_NONSEQ) begin
            s_busy <= 1'b1;
            s_left <= cfg_waits;
        end else if (s_busy) begin
            if (s_left == 0) s_busy <= 1'b0;
            else             s_left <= s_left - 1;
        end
    end

    assign pt_hready = s_busy ? (s_left == 0) : 1'b1;
    assign pt_hresp  = (s_busy && s_left == 0) ? cfg_resp : HRESP_OKAY;
    assign pt_hrdata = cfg_rdata;

    // observations filled in by the driver
    int            obs_low, obs_data, obs_to, obs_wd_bad;
    logic [1:0]    obs_resp, obs_last_resp;
    logic [DW-1:0] obs_rdata;
    logic          obs_pt_hsel, obs_pt_hwrite;
    logic [1:0]    obs_pt_htrans;
    logic [31:0]   obs_pt_haddr;
    logic [2:0]    obs_pt_hsize;

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hready = 1'b1;
        haddr  = 32'd0;
        hwrite = 1'b0;
        hsize  = 3'd0;
    endtask

    task automatic present(input logic [31:0] a, input logic wr, input logic [2:0] sz);
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        hready = 1'b1;
        haddr  = a;
        hwrite = wr;
        hsize  = sz;
    endtask

    // one complete transfer from the accept cycle up to the first hready_o=1
    task automatic run_xfer(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                            input logic [DW-1:0] wd);
        obs_low = 0; obs_data = 0; obs_to = 0; obs_wd_bad = 0;
        obs_resp = 2'bxx; obs_last_resp = 2'bxx; obs_rdata = 'x;
        present(a, wr, sz);
        @(negedge clk);
        @(posedge clk); #1;
        bus_idle();
        hwdata = wd;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (timeout_o === 1'b1) obs_to++;
            if (hready_o === 1'b1) begin
                obs_resp  = hresp;
                obs_rdata = hrdata;
                break;
            end
            if (obs_low == 0) begin
                obs_pt_hsel   = pt_hsel;
                obs_pt_htrans = pt_htrans;
                obs_pt_haddr  = pt_haddr;
                obs_pt_hwrite = pt_hwrite;
                obs_pt_hsize  = pt_hsize;
            end
            if (o_dbg_state === ST_DATA) begin
                obs_data++;
                if (pt_hwdata !== wd || pt_hsel !== 1'b0) obs_wd_bad++;
            end
            obs_low++;
            obs_last_resp = hresp;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus_idle();
        hwdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({hready_o, hresp, hrdata} !== {1'b1, 2'b00, 32'h0}) begin
            bad++; $display("FAIL reset_bus: got %h want %h", {hready_o, hresp, hrdata}, {1'b1, 2'b00, 32'h0});
        end
        total++;
        if ({pt_hsel, pt_haddr, pt_hwrite, pt_htrans, pt_hsize, pt_hwdata} !== 71'h0) begin
            bad++; $display("FAIL reset_pt: got %h want 0", {pt_hsel, pt_haddr, pt_hwrite, pt_htrans, pt_hsize, pt_hwdata});
        end
        total++;
        if ({timeout_o, err_cnt, o_dbg_state} !== {1'b0, 16'h0, ST_IDLE}) begin
            bad++; $display("FAIL reset_status: got %h want %h", {timeout_o, err_cnt, o_dbg_state}, {1'b0, 16'h0, ST_IDLE});
        end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_idle_okay();
        logic [1:0] tr [4] = '{HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ};
        logic       sl [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic       rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            hsel = sl[k]; htrans = tr[k]; hready = rd[k];
            haddr = 32'h4000_0000 + 32'(k); hwrite = 1'b0; hsize = 3'd2;
            @(negedge clk);
            total++;
            if ({hready_o, hresp} !== 3'b100) begin
                bad++; $display("FAIL idle_okay_%0d: got %b want 100", k, {hready_o, hresp});
            end
            @(posedge clk); #1;
            bus_idle();
            @(negedge clk);
            total++;
            if (o_dbg_state !== ST_IDLE || pt_hsel !== 1'b0) begin
                bad++; $display("FAIL no_accept_%0d: got state %0d pt_hsel %b want 0 0", k, o_dbg_state, pt_hsel);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_read();
        logic [DW-1:0] e;
        cfg_waits = 0; cfg_resp = HRESP_OKAY; cfg_rdata = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        run_xfer(32'h4000_0010, 1'b0, 3'd2, $urandom);
        e = exp_q.pop_front();
        total++;
        if (obs_low !== 2) begin bad++; $display("FAIL read_waits: got %0d want 2", obs_low); end
        total++;
        if (obs_resp !== HRESP_OKAY || obs_rdata !== e) begin
            bad++; $display("FAIL read_data: got resp %b data %h want 00 %h", obs_resp, obs_rdata, e);
        end
        total++;
        if ({obs_pt_hsel, obs_pt_htrans, obs_pt_haddr, obs_pt_hwrite, obs_pt_hsize} !==
            {1'b1, HTRANS_NONSEQ, 32'h4000_0010, 1'b0, 3'd2}) begin
            bad++; $display("FAIL read_addr_phase: got %h want %h",
                {obs_pt_hsel, obs_pt_htrans, obs_pt_haddr, obs_pt_hwrite, obs_pt_hsize},
                {1'b1, HTRANS_NONSEQ, 32'h4000_0010, 1'b0, 3'd2});
        end
    endtask

    task automatic test_write_waits();
        logic [DW-1:0] e;
        cfg_waits = 5; cfg_resp = HRESP_OKAY; cfg_rdata = 32'hBAD0_0001;
        exp_q.push_back(32'hDEAD_BEEF);   // writes leave hrdata untouched
        run_xfer(32'h4000_0020, 1'b1, 3'd1, 32'h1234_5678);
        e = exp_q.pop_front();
        total++;
        if (obs_low !== 7 || obs_data !== 6) begin
            bad++; $display("FAIL write_waits: got low %0d data %0d want 7 6", obs_low, obs_data);
        end
        total++;
        if (obs_wd_bad !== 0) begin bad++; $display("FAIL write_hwdata_hold: got %0d bad cycles want 0", obs_wd_bad); end
        total++;
        if (obs_resp !== HRESP_OKAY || obs_rdata !== e || obs_pt_hwrite !== 1'b1 || obs_pt_hsize !== 3'd1) begin
            bad++; $display("FAIL write_done: got resp %b rdata %h wr %b sz %0d want 00 %h 1 1",
                obs_resp, obs_rdata, obs_pt_hwrite, obs_pt_hsize, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        int low;
        cfg_waits = 0; cfg_resp = HRESP_OKAY; cfg_rdata = 32'h1111_1111;
        present(32'h4000_0100, 1'b0, 3'd2);
        exp_q.push_back(32'h1111_1111);
        @(negedge clk);
        @(posedge clk); #1; bus_idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        present(32'h4000_0104, 1'b0, 3'd2);
        exp_q.push_back(32'h2222_2222);
        cfg_rdata = 32'h2222_2222;
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (o_dbg_state !== ST_RESP || hready_o !== 1'b1 || hrdata !== e) begin
            bad++; $display("FAIL b2b_first: got state %0d rdy %b data %h want 3 1 %h", o_dbg_state, hready_o, hrdata, e);
        end
        @(posedge clk); #1; bus_idle();
        @(negedge clk);
        total++;
        if (o_dbg_state !== ST_ADDR || pt_hsel !== 1'b1 || pt_haddr !== 32'h4000_0104) begin
            bad++; $display("FAIL b2b_addr: got state %0d sel %b addr %h want 1 1 40000104", o_dbg_state, pt_hsel, pt_haddr);
        end
        low = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (hready_o === 1'b1) break;
            low++;
        end
        e = exp_q.pop_front();
        total++;
        if (low !== 2 || hrdata !== e) begin
            bad++; $display("FAIL b2b_second: got low %0d data %h want 2 %h", low, hrdata, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        cfg_waits = 1000; cfg_resp = HRESP_OKAY; cfg_rdata = 32'h5555_AAAA;
        run_xfer(32'h4000_0200, 1'b0, 3'd2, $urandom);
        exp_err++;
        total++;
        if (obs_data !== TMO || obs_low !== TMO + 2) begin
            bad++; $display("FAIL timeout_len: got data %0d low %0d want %0d %0d", obs_data, obs_low, TMO, TMO + 2);
        end
        total++;
        if (obs_last_resp !== HRESP_ERROR || obs_resp !== HRESP_ERROR) begin
            bad++; $display("FAIL timeout_resp: got err1 %b err2 %b want 01 01", obs_last_resp, obs_resp);
        end
        total++;
        if (obs_to !== 1 || err_cnt !== 16'(exp_err)) begin
            bad++; $display("FAIL timeout_flag: got pulses %0d err_cnt %0d want 1 %0d", obs_to, err_cnt, exp_err);
        end
    endtask

    task automatic test_timeout_edge();
        logic [DW-1:0] e;
        cfg_waits = TMO - 1; cfg_resp = HRESP_OKAY; cfg_rdata = 32'h0BAD_CAFE;
        exp_q.push_back(32'h0BAD_CAFE);
        run_xfer(32'h4000_0300, 1'b0, 3'd0, $urandom);
        e = exp_q.pop_front();
        total++;
        if (obs_data !== TMO || obs_resp !== HRESP_OKAY || obs_rdata !== e || obs_to !== 0) begin
            bad++; $display("FAIL timeout_edge: got data %0d resp %b rdata %h pulses %0d want %0d 00 %h 0",
                obs_data, obs_resp, obs_rdata, obs_to, TMO, e);
        end
        total++;
        if (err_cnt !== 16'(exp_err)) begin bad++; $display("FAIL timeout_edge_cnt: got %0d want %0d", err_cnt, exp_err); end
    endtask

    task automatic test_error_resp();
        logic [1:0] rs [2] = '{HRESP_ERROR, HRESP_SPLIT};
        for (int k = 0; k < 2; k++) begin
            cfg_waits = 2; cfg_resp = rs[k]; cfg_rdata = 32'h7777_0000;
            run_xfer(32'h4000_0400, 1'b1, 3'd2, $urandom);
            exp_err++;
            total++;
            if (obs_low !== 5 || obs_last_resp !== HRESP_ERROR || obs_resp !== HRESP_ERROR) begin
                bad++; $display("FAIL err_resp_%0d: got low %0d err1 %b err2 %b want 5 01 01", k, obs_low, obs_last_resp, obs_resp);
            end
            total++;
            if (obs_to !== 0 || err_cnt !== 16'(exp_err)) begin
                bad++; $display("FAIL err_cnt_%0d: got pulses %0d cnt %0d want 0 %0d", k, obs_to, err_cnt, exp_err);
            end
        end
    endtask

    task automatic test_err2_cancel();
        cfg_waits = 0; cfg_resp = HRESP_RETRY;
        present(32'h4000_0500, 1'b0, 3'd2);
        @(negedge clk);
        @(posedge clk); #1; bus_idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        exp_err++;
        total++;
        if (o_dbg_state !== ST_ERR1 || hready_o !== 1'b0 || hresp !== HRESP_ERROR || err_cnt !== 16'(exp_err)) begin
            bad++; $display("FAIL retry_err1: got state %0d rdy %b resp %b cnt %0d want 4 0 01 %0d",
                o_dbg_state, hready_o, hresp, err_cnt, exp_err);
        end
        @(posedge clk); #1;
        present(32'h4000_0600, 1'b0, 3'd2);
        @(negedge clk);
        total++;
        if (o_dbg_state !== ST_ERR2 || hready_o !== 1'b1 || hresp !== HRESP_ERROR) begin
            bad++; $display("FAIL retry_err2: got state %0d rdy %b resp %b want 5 1 01", o_dbg_state, hready_o, hresp);
        end
        @(posedge clk); #1; bus_idle();
        @(negedge clk);
        total++;
        if (o_dbg_state !== ST_IDLE || pt_hsel !== 1'b0) begin
            bad++; $display("FAIL err2_cancel: got state %0d sel %b want 0 0", o_dbg_state, pt_hsel);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        cfg_waits = 10; cfg_resp = HRESP_OKAY;
        present(32'h4000_0700, 1'b1, 3'd2);
        @(negedge clk);
        @(posedge clk); #1; bus_idle(); hwdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        total++;
        if (o_dbg_state !== ST_DATA || pt_hwdata !== 32'hA5A5_A5A5 || err_cnt !== 16'(exp_err)) begin
            bad++; $display("FAIL pre_reset: got state %0d wd %h cnt %0d want 2 a5a5a5a5 %0d", o_dbg_state, pt_hwdata, err_cnt, exp_err);
        end
        @(posedge clk); #1;
        @(negedge clk);
        exp_err = 0;
        total++;
        if ({hready_o, hresp, hrdata, timeout_o, err_cnt, o_dbg_state} !== {1'b1, 2'b00, 32'h0, 1'b0, 16'h0, ST_IDLE}) begin
            bad++; $display("FAIL mid_reset_status: got %h want %h", {hready_o, hresp, hrdata, timeout_o, err_cnt, o_dbg_state},
                {1'b1, 2'b00, 32'h0, 1'b0, 16'h0, ST_IDLE});
        end
        total++;
        if ({pt_hsel, pt_haddr, pt_hwrite, pt_htrans, pt_hsize, pt_hwdata} !== 71'h0) begin
            bad++; $display("FAIL mid_reset_pt: got %h want 0", {pt_hsel, pt_haddr, pt_hwrite, pt_htrans, pt_hsize, pt_hwdata});
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_idle_okay();
        test_read();
        test_write_waits();
        test_back_to_back();
        test_timeout();
        test_timeout_edge();
        test_error_resp();
        test_err2_cancel();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL queue_left: got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
